seq_div_cla: RTL and testbench

//  Iterative restoring divider: the inverse companion of the shift-add multiplier.

---
 rtl/seq_div_cla.sv | 270 +++++++++++++++++++++++++++
 tb/tb_seq_div_cla.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_cla.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// seq_div_cla
//   Iterative restoring divider producing one quotient bit per clock. Each
//   trial subtraction P - divisor is computed as P + ~divisor + 1 on a chain
//   of 4-bit carry-lookahead slices. Shares the start/done handshake of the
//   shift-add multiplier it sits beside.
//
//   Optional feature macro: DIV_SIGNED_EN
//     defined   - two's complement operands; magnitudes are divided and one
//                 extra SFIX cycle applies the result signs (truncation
//                 toward zero). Latency WIDTH+1.
//     undefined - unsigned only. Latency WIDTH.
//
// Parameters
//   WIDTH        operand/result width, must be a multiple of 4
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   start        request, sampled only in IDLE or FIN
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         high while an operation is iterating (RUN / SFIX)
//   done         one-cycle pulse, results valid in this cycle
//   quotient     result, held until the next result is loaded
//   remainder    result, held until the next result is loaded
//   div_by_zero  set with done when divisor was zero, held with results
// ---------------------------------------------------------------------------
module seq_div_cla #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int NSL = WIDTH / 4;
    localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
`ifdef DIV_SIGNED_EN
        S_SFIX = 2'd2,
`endif
        S_FIN  = 2'd3
    } state_t;

    // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c[4], p ^ c[3:0]};
    endfunction

`ifdef DIV_SIGNED_EN
    // Magnitude of a two's complement value; the most negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] m;
        if (x[WIDTH-1]) begin
            m = ~x + WIDTH'(1);
        end else begin
            m = x;
        end
        return m;
    endfunction
`endif

    state_t           state_r, state_nx;
    logic [CW-1:0]    cnt_r, cnt_nx;
    // Partial remainder. The invariant P < divisor keeps it within WIDTH
    // bits between iterations; only the shifted value needs WIDTH+1 bits.
    logic [WIDTH-1:0] p_r, p_nx;
    logic [WIDTH-1:0] q_r, q_nx;
    logic [WIDTH-1:0] dvs_r, dvs_nx;
    logic [WIDTH-1:0] quo_r, quo_nx;
    logic [WIDTH-1:0] rem_r, rem_nx;
    logic             dbz_r, dbz_nx;
    logic             busy_r, busy_nx;
    logic             done_r, done_nx;
`ifdef DIV_SIGNED_EN
    logic             neg_q_r, neg_q_nx;
    logic             neg_r_r, neg_r_nx;
`endif

    logic [WIDTH:0]   p_sh_s;
    logic [WIDTH-1:0] b_inv_s;
    logic [WIDTH-1:0] diff_s;
    logic             chain_cout_s;
    logic             no_borrow_s;

    assign p_sh_s  = {p_r, q_r[WIDTH-1]};
    assign b_inv_s = ~dvs_r;

    // Trial subtraction of the low WIDTH bits through the CLA slice chain
    always_comb begin
        logic       c_v;
        logic [4:0] s_v;
        c_v    = 1'b1;
        s_v    = 5'b0;
        diff_s = '0;
        for (int i = 0; i < NSL; i++) begin
            s_v               = cla4(p_sh_s[4*i +: 4], b_inv_s[4*i +: 4], c_v);
            diff_s[4*i +: 4]  = s_v[3:0];
            c_v               = s_v[4];
        end
        chain_cout_s = c_v;
    end

    // Top bit of the WIDTH+1-bit subtraction: the divisor's extension bit is
    // 0, so its inverted form is 1 and the carry-out reduces to an OR.
    assign no_borrow_s = p_sh_s[WIDTH] | chain_cout_s;

    // Next-state, datapath and output-register next values
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        p_nx     = p_r;
        q_nx     = q_r;
        dvs_nx   = dvs_r;
        quo_nx   = quo_r;
        rem_nx   = rem_r;
        dbz_nx   = dbz_r;
`ifdef DIV_SIGNED_EN
        neg_q_nx = neg_q_r;
        neg_r_nx = neg_r_r;
`endif
        case (state_r)
            S_IDLE, S_FIN: begin
                if (start) begin
                    if (divisor != '0) begin
                        dbz_nx   = 1'b0;
                        cnt_nx   = CW'(WIDTH - 1);
                        p_nx     = '0;
`ifdef DIV_SIGNED_EN
                        q_nx     = mag(dividend);
                        dvs_nx   = mag(divisor);
                        neg_q_nx = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r_nx = dividend[WIDTH-1];
`else
                        q_nx     = dividend;
                        dvs_nx   = divisor;
`endif
                        state_nx = S_RUN;
                    end else begin
                        quo_nx   = {WIDTH{1'b1}};
                        rem_nx   = dividend;
                        dbz_nx   = 1'b1;
                        dvs_nx   = divisor;
                        state_nx = S_FIN;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (no_borrow_s) begin
                    p_nx = diff_s;
                end else begin
                    p_nx = p_sh_s[WIDTH-1:0];
                end
                q_nx = {q_r[WIDTH-2:0], no_borrow_s};
                if (cnt_r == '0) begin
`ifdef DIV_SIGNED_EN
                    state_nx = S_SFIX;
`else
                    quo_nx   = q_nx;
                    rem_nx   = p_nx;
                    state_nx = S_FIN;
`endif
                end else begin
                    cnt_nx = cnt_r - CW'(1);
                end
            end
`ifdef DIV_SIGNED_EN
            S_SFIX: begin
                if (neg_q_r) begin
                    quo_nx = ~q_r + WIDTH'(1);
                end else begin
                    quo_nx = q_r;
                end
                if (neg_r_r) begin
                    rem_nx = ~p_r + WIDTH'(1);
                end else begin
                    rem_nx = p_r;
                end
                state_nx = S_FIN;
            end
`endif
            default: begin
                state_nx = S_IDLE;
            end
        endcase
        done_nx = (state_nx == S_FIN);
`ifdef DIV_SIGNED_EN
        busy_nx = (state_nx == S_RUN) || (state_nx == S_SFIX);
`else
        busy_nx = (state_nx == S_RUN);
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            p_r     <= '0;
            q_r     <= '0;
            dvs_r   <= '0;
            quo_r   <= '0;
            rem_r   <= '0;
            dbz_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
`endif
        end else begin
            cnt_r   <= cnt_nx;
            p_r     <= p_nx;
            q_r     <= q_nx;
            dvs_r   <= dvs_nx;
            quo_r   <= quo_nx;
            rem_r   <= rem_nx;
            dbz_r   <= dbz_nx;
            busy_r  <= busy_nx;
            done_r  <= done_nx;
`ifdef DIV_SIGNED_EN
            neg_q_r <= neg_q_nx;
            neg_r_r <= neg_r_nx;
`endif
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quo_r;
    assign remainder   = rem_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_div_cla.sv
`timescale 1ns/1ps
module tb_seq_div_cla;

    localparam int W = 8;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_div_cla #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    exp_t last;
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    logic [W-1:0] tab_a [0:6] = '{8'd100, 8'd255, 8'd3,   8'd0, 8'd200, 8'd254, 8'd7};
    logic [W-1:0] tab_b [0:6] = '{8'd7,   8'd1,   8'd200, 8'd5, 8'd200, 8'd15,  8'd255};

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // Reference model: plain integer division
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t m;
`ifdef DIV_SIGNED_EN
        int sa;
        int sbv;
`endif
        if (b == '0) begin
            m.q   = '1;
            m.r   = a;
            m.dbz = 1'b1;
            m.lat = 0;
        end else begin
`ifdef DIV_SIGNED_EN
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            m.q = W'(sa / sbv);
            m.r = W'(sa % sbv);
`else
            m.q = a / b;
            m.r = a % b;
`endif
            m.dbz = 1'b0;
            m.lat = LAT;
        end
        return m;
    endfunction

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts active edges from the last accepting edge until done is seen
    task automatic wait_done(output int lat, output bit to);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        to   = 1'b0;
        while (!seen && !to) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
            else begin
                lat++;
                if (lat > 4 * W) to = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (quotient !== '0) begin n_err++; $display("FAIL reset_q: got %h want 00", quotient); end
        n_cmp++; if (remainder !== '0) begin n_err++; $display("FAIL reset_r: got %h want 00", remainder); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic;
        int lat;
        bit to;
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            launch(tab_a[i], tab_b[i]);
            wait_done(lat, to);
            e = sb.pop_front();
            last = e;
            n_cmp++; if (to || lat !== e.lat) begin n_err++; $display("FAIL basic_lat[%0d]: got %0d (timeout %0d) want %0d", i, lat, to, e.lat); end
            n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL basic_q[%0d]: got %h want %h", i, quotient, e.q); end
            n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL basic_r[%0d]: got %h want %h", i, remainder, e.r); end
            n_cmp++; if (div_by_zero !== e.dbz) begin n_err++; $display("FAIL basic_dbz[%0d]: got %b want %b", i, div_by_zero, e.dbz); end
            @(negedge clk);
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_pulse[%0d]: got %b want 0", i, done); end
        end
    endtask

    task automatic test_div_zero;
        int lat;
        bit to;
        exp_t e;
        launch(8'd13, 8'd0);
        wait_done(lat, to);
        e = sb.pop_front();
        n_cmp++; if (to || lat !== 0) begin n_err++; $display("FAIL dz_lat: got %0d want 0", lat); end
        n_cmp++; if (quotient !== 8'hFF) begin n_err++; $display("FAIL dz_q: got %h want ff", quotient); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL dz_r: got %h want %h", remainder, e.r); end
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
        @(negedge clk);
        n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dz_hold: got %b want 1", div_by_zero); end
        launch(8'd20, 8'd3);
        wait_done(lat, to);
        e = sb.pop_front();
        last = e;
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dz_clear: got %b want 0", div_by_zero); end
        n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL dz_next_q: got %h want %h", quotient, e.q); end
    endtask

    task automatic test_busy_ignore;
        int lat;
        bit to;
        exp_t e;
        launch(8'd100, 8'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bi_busy: got %b want 1", busy); end
        n_cmp++; if (quotient !== last.q) begin n_err++; $display("FAIL bi_stable_q: got %h want %h", quotient, last.q); end
        n_cmp++; if (remainder !== last.r) begin n_err++; $display("FAIL bi_stable_r: got %h want %h", remainder, last.r); end
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, to);
        e = sb.pop_front();
        last = e;
        n_cmp++; if (to || lat !== LAT - 3) begin n_err++; $display("FAIL bi_lat: got %0d want %0d", lat, LAT - 3); end
        n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL bi_q: got %h want %h", quotient, e.q); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL bi_r: got %h want %h", remainder, e.r); end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit to;
        int c0;
        exp_t e;
        @(negedge clk);
        c0 = done_cnt;
        dividend = 8'd50; divisor = 8'd5; start = 1'b1;
        sb.push_back(model(8'd50, 8'd5));
        @(posedge clk);
        #1;
        wait_done(lat, to);
        e = sb.pop_front();
        n_cmp++; if (to || lat !== LAT) begin n_err++; $display("FAIL b2b_lat1: got %0d want %0d", lat, LAT); end
        n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL b2b_q1: got %h want %h", quotient, e.q); end
        sb.push_back(model(8'd50, 8'd5));
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, to);
        e = sb.pop_front();
        last = e;
        n_cmp++; if (to || lat !== LAT) begin n_err++; $display("FAIL b2b_lat2: got %0d want %0d", lat, LAT); end
        n_cmp++; if (quotient !== 8'd10) begin n_err++; $display("FAIL b2b_q2: got %h want 0a", quotient); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL b2b_r2: got %h want %h", remainder, e.r); end
        repeat (3) @(negedge clk);
        n_cmp++; if (done_cnt - c0 !== 2) begin n_err++; $display("FAIL b2b_pulses: got %0d want 2", done_cnt - c0); end
    endtask

    task automatic test_reset_mid;
        int lat;
        bit to;
        exp_t e;
        launch(8'd100, 8'd7);
        sb.delete();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rm_done: got %b want 0", done); end
        n_cmp++; if (quotient !== '0) begin n_err++; $display("FAIL rm_q: got %h want 00", quotient); end
        n_cmp++; if (remainder !== '0) begin n_err++; $display("FAIL rm_r: got %h want 00", remainder); end
        @(negedge clk);
        rst = 1'b0;
        launch(8'd9, 8'd2);
        wait_done(lat, to);
        e = sb.pop_front();
        n_cmp++; if (to || lat !== LAT) begin n_err++; $display("FAIL rm_lat: got %0d want %0d", lat, LAT); end
        n_cmp++; if (quotient !== 8'd4) begin n_err++; $display("FAIL rm_q2: got %h want 04", quotient); end
        n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL rm_r2: got %h want %h", remainder, e.r); end
    endtask

`ifdef DIV_SIGNED_EN
    logic [W-1:0] sg_a [0:3] = '{8'h9C, 8'h80, 8'd100, 8'hF9};
    logic [W-1:0] sg_b [0:3] = '{8'd7,  8'hFF, 8'hF9,  8'd0};

    task automatic test_signed;
        int lat;
        bit to;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            launch(sg_a[i], sg_b[i]);
            wait_done(lat, to);
            e = sb.pop_front();
            n_cmp++; if (to || lat !== e.lat) begin n_err++; $display("FAIL sg_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
            n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL sg_q[%0d]: got %h want %h", i, quotient, e.q); end
            n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL sg_r[%0d]: got %h want %h", i, remainder, e.r); end
            n_cmp++; if (div_by_zero !== e.dbz) begin n_err++; $display("FAIL sg_dbz[%0d]: got %b want %b", i, div_by_zero, e.dbz); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
